// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoding constants, shared by the instruction decoder and encoder.
// Holds the opcode map, the immediate-format codes, the canonical NOP and small helpers.
package rv_isa_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_B    = 3'b010,
    IMM_U    = 3'b011,
    IMM_J    = 3'b100,
    IMM_NONE = 3'b111
  } imm_type_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } enc_state_e;

  // R-type and unknown opcodes both map to IMM_NONE; callers tell them apart by opcode.
  function automatic imm_type_e imm_type_of(input logic [6:0] op);
    imm_type_e t;
    case (op)
      OP_IMM, OP_LOAD, OP_JALR: t = IMM_I;
      OP_STORE:                 t = IMM_S;
      OP_BRANCH:                t = IMM_B;
      OP_LUI, OP_AUIPC:         t = IMM_U;
      OP_JAL:                   t = IMM_J;
      default:                  t = IMM_NONE;
    endcase
    return t;
  endfunction

  // True when v[31:lsb] are all equal, i.e. v is a sign extension of v[lsb:0].
  function automatic logic sext_fits(input logic [31:0] v, input int unsigned lsb);
    logic [31:0] s;
    s = 32'($signed(v) >>> lsb);
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer: builds the instruction word for the opcode's format
// and flags encodings whose opcode is unknown or whose immediate does not fit.
module instr_pack
  import rv_isa_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP
) (
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  logic [31:0] word;
  logic        legal;

  always_comb begin
    word  = '0;
    legal = 1'b0;
    if (opcode == OP_R) begin
      word  = {funct7, rs2, rs1, funct3, rd, opcode};
      legal = 1'b1;
    end else begin
      case (imm_type_of(opcode))
        IMM_I: begin
          word  = {imm[11:0], rs1, funct3, rd, opcode};
          legal = sext_fits(imm, 11);
        end
        IMM_S: begin
          word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
          legal = sext_fits(imm, 11);
        end
        IMM_B: begin
          word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
          legal = !imm[0] && sext_fits(imm, 12);
        end
        IMM_J: begin
          word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
          legal = !imm[0] && sext_fits(imm, 20);
        end
        IMM_U: begin
          word  = {imm[31:12], rd, opcode};
          legal = (imm[11:0] == 12'h000);
        end
        default: begin
          word  = '0;
          legal = 1'b0;
        end
      endcase
    end
    instr = legal ? word : NOP_WORD;
    err   = !legal;
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder on the program-load path: packs field bundles into words,
// stamps sequential byte addresses and buffers them in a 2-entry output FIFO.
module instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          LEN_W    = 16,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  prog_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              busy,
  output logic              done
);

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        count_q, count_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;

  logic [31:0]       fifo_instr_q [2];
  logic [ADDR_W-1:0] fifo_addr_q  [2];
  logic              fifo_err_q   [2];

  logic [31:0] pk_instr;
  logic        pk_err;
  logic        push;
  logic        pop;

  instr_pack #(.NOP_WORD(NOP_WORD)) u_pack (
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .imm    (imm),
    .instr  (pk_instr),
    .err    (pk_err)
  );

  assign in_ready  = (state_q == ST_ACTIVE) && (count_q != 2'd2);
  assign push      = in_valid && in_ready;
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_instr = fifo_instr_q[rd_ptr_q];
  assign out_addr  = fifo_addr_q[rd_ptr_q];
  assign out_err   = fifo_err_q[rd_ptr_q];
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    done     = 1'b0;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // The low two address bits are forced to zero so words stay 4-aligned.
          addr_d  = base_addr & ~ADDR_W'(3);
          len_d   = prog_len;
          cnt_d   = '0;
          state_d = (prog_len == '0) ? ST_DRAIN : ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (push) begin
          addr_d = addr_q + ADDR_W'(4);
          cnt_d  = cnt_q + LEN_W'(1);
          if (cnt_q + LEN_W'(1) == len_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (count_q == 2'd0) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      count_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_addr_q[i]  <= '0;
        fifo_err_q[i]   <= 1'b0;
      end
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) begin
        fifo_instr_q[wr_ptr_q] <= pk_instr;
        fifo_addr_q[wr_ptr_q]  <= addr_q;
        fifo_err_q[wr_ptr_q]   <= pk_err;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded RV32I words, address stamping,
// illegal-encoding replacement, backpressure, address wrap, empty program and reset abort.
module tb_instr_encoder;
  import rv_isa_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] prog_len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic        busy;
  logic        done;

  instr_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .prog_len  (prog_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .out_err   (out_err),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int hs_cyc   = -1;
  int done_cnt = 0;
  logic [64:0] q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Outputs are observed on the falling edge; inputs change 1 time unit after the rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        q.push_back({out_err, out_addr, out_instr});
        hs_cyc <= cyc;
        $display("xfer  cyc=%0d addr=%08h instr=%08h err=%0b", cyc, out_addr, out_instr, out_err);
      end
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic check_word(input string tag, input int idx, input logic [31:0] instr,
                            input logic [31:0] addr, input logic err);
    logic [64:0] got;
    got = (idx < q.size()) ? q[idx] : '1;
    check(tag, got, {err, addr, instr});
  endtask

  task automatic do_start(input logic [31:0] b, input logic [15:0] l);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; prog_len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [31:0] im);
    bit ok;
    ok = 1'b0;
    opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    if (!ok) check("send_accept", 65'(ok), 65'd1);
  endtask

  task automatic wait_done(input string tag, output int dc);
    bit seen;
    seen = 1'b0;
    dc = -1;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        dc = cyc;
      end
    end
    check(tag, 65'(seen), 65'd1);
  endtask

  int dc;
  int dcnt_before;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_outs", {58'd0, in_ready, out_valid, out_err, busy, done, 2'b00}, 65'd0);
    check("rst_instr_addr", {1'b0, out_addr, out_instr}, 65'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single addi x1,x0,5
    q.delete();
    do_start(32'h0000_0100, 16'd1);
    check("t1_busy", 65'(busy), 65'd1);
    send(OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    wait_done("t1_done", dc);
    check("t1_done_lat", 65'(dc - hs_cyc), 65'd1);
    check("t1_count", 65'(q.size()), 65'd1);
    check_word("t1_addi", 0, 32'h0050_0093, 32'h0000_0100, 1'b0);
    @(posedge clk); #1;
    check("t1_idle", 65'(busy), 65'd0);

    // sw / beq / jal / lui
    q.delete();
    do_start(32'h0000_0200, 16'd4);
    send(OP_STORE,  3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    send(OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    send(OP_JAL,    3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd16);
    send(OP_LUI,    3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
    wait_done("t2_done", dc);
    check("t2_count", 65'(q.size()), 65'd4);
    check_word("t2_sw",  0, 32'h0020_A423, 32'h0000_0200, 1'b0);
    check_word("t2_beq", 1, 32'h0020_8463, 32'h0000_0204, 1'b0);
    check_word("t2_jal", 2, 32'h0100_00EF, 32'h0000_0208, 1'b0);
    check_word("t2_lui", 3, 32'h1234_52B7, 32'h0000_020C, 1'b0);

    // Illegal encodings become NOP with err set
    q.delete();
    do_start(32'h0000_0300, 16'd3);
    send(OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
    send(OP_IMM,    3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
    send(7'h7F,     3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
    wait_done("t3_done", dc);
    check_word("t3_b_odd",  0, 32'h0000_0013, 32'h0000_0300, 1'b1);
    check_word("t3_i_big",  1, 32'h0000_0013, 32'h0000_0304, 1'b1);
    check_word("t3_bad_op", 2, 32'h0000_0013, 32'h0000_0308, 1'b1);

    // Backpressure: two words buffered, head held stable
    q.delete();
    out_ready = 1'b0;
    do_start(32'h0000_0400, 16'd3);
    send(OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    send(OP_IMM, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd2);
    @(negedge clk);
    check("t4_full_ready", 65'(in_ready), 65'd0);
    check("t4_head", {1'b0, out_addr, out_instr}, {1'b0, 32'h0000_0400, 32'h0010_0093});
    repeat (3) @(negedge clk);
    check("t4_head_hold", {out_valid, out_addr, out_instr}, {1'b1, 32'h0000_0400, 32'h0010_0093});
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(OP_IMM, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd3);
    wait_done("t4_done", dc);
    check("t4_count", 65'(q.size()), 65'd3);
    check_word("t4_w0", 0, 32'h0010_0093, 32'h0000_0400, 1'b0);
    check_word("t4_w1", 1, 32'h0020_0113, 32'h0000_0404, 1'b0);
    check_word("t4_w2", 2, 32'h0030_0193, 32'h0000_0408, 1'b0);

    // Address wrap
    q.delete();
    do_start(32'hFFFF_FFFC, 16'd2);
    send(OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    send(OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    wait_done("t5_done", dc);
    check_word("t5_w0", 0, 32'h0050_0093, 32'hFFFF_FFFC, 1'b0);
    check_word("t5_w1", 1, 32'h0050_0093, 32'h0000_0000, 1'b0);

    // Empty program
    q.delete();
    do_start(32'h0000_0700, 16'd0);
    wait_done("t6_done", dc);
    check("t6_no_words", 65'(q.size()), 65'd0);

    // Reset in ACTIVE with one word buffered
    q.delete();
    out_ready = 1'b0;
    do_start(32'h0000_0500, 16'd3);
    send(OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    @(negedge clk);
    check("t7_buffered", 65'(out_valid), 65'd1);
    @(posedge clk); #1;
    dcnt_before = done_cnt;
    rst = 1'b1;
    #1;
    check("t7_rst_flags", {62'd0, out_valid, in_ready, busy}, 65'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("t7_no_done", 65'(done_cnt), 65'(dcnt_before));
    do_start(32'h0000_0600, 16'd1);
    send(OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    wait_done("t7_restart_done", dc);
    check("t7_count", 65'(q.size()), 65'd1);
    check_word("t7_restart", 0, 32'h0050_0093, 32'h0000_0600, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $finish;
  end

endmodule
